// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the serial FIR filter.
// Output stage math is done at a fixed wide width, sliced by callers.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN,
    OUT
  } fir_state_t;

  localparam int SR_W  = 128;
  localparam int MAX_W = 64;

  function automatic int acc_w(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction

  // Returns {clipped, value}; value is sign-correct in its low w bits.
  function automatic logic [MAX_W:0] sat_round(
    input logic signed [SR_W-1:0] acc,
    input int                     w,
    input int                     w_frac,
    input bit                     rnd
  );
    logic signed [SR_W-1:0] r;
    logic signed [SR_W-1:0] hi;
    logic signed [SR_W-1:0] lo;
    r = acc;
    if (rnd && w_frac > 0)
      r = r + (SR_W'(1) << (w_frac - 1));
    r  = r >>> w_frac;
    hi = (SR_W'(1) << (w - 1)) - SR_W'(1);
    lo = -hi - SR_W'(1);
    if (r > hi)
      return {1'b1, hi[MAX_W-1:0]};
    if (r < lo)
      return {1'b1, lo[MAX_W-1:0]};
    return {1'b0, r[MAX_W-1:0]};
  endfunction

endpackage

// File: rtl/fir_stream_serial_mac.sv
// Time-shared multiply-accumulate: one registered product stage
// feeding a wide accumulator that cannot overflow for N terms.
module fir_mac
  import fir_pkg::*;
#(
  parameter int W     = 32,
  parameter int ACC_W = 70
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*W-1:0] prod;
  logic                  prod_vld;

  // Product register, then accumulate one cycle behind the issue.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod     <= $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      prod_vld <= en;
      if (prod_vld)
        acc <= acc + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
    end
  end

endmodule

// File: rtl/fir_stream_serial.sv
// Streaming FIR with one shared multiplier, loadable taps,
// valid/ready on both sides and a saturating rounded output.
module fir_stream_serial
  import fir_pkg::*;
#(
  parameter int N      = 41,
  parameter int W      = 32,
  parameter int W_FRAC = 16,
  parameter int ROUND  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic [W-1:0]         x_data,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [W-1:0]         y_data,
  output logic                 y_sat,
  input  logic                 coef_wr_en,
  output logic                 coef_wr_ready,
  input  logic [$clog2(N)-1:0] coef_wr_addr,
  input  logic [W-1:0]         coef_wr_data
);

  localparam int ACC_W = acc_w(W, N);
  localparam int AW    = $clog2(N);

  fir_state_t state, state_nxt;

  logic [AW-1:0]          wptr;
  logic [AW-1:0]          k;
  logic [AW-1:0]          idx;
  logic                   k_last;
  logic                   x_hs;
  logic                   c_hs;
  logic                   mac_en;
  logic signed [W-1:0]    dl [N];
  logic signed [W-1:0]    h  [N];
  logic signed [ACC_W-1:0] acc;
  logic signed [SR_W-1:0] acc_x;
  logic [MAX_W:0]         sr;
  logic                   unused_sr;

  assign k_last = (k == AW'(N - 1));
  assign x_hs   = x_valid & x_ready;
  assign c_hs   = coef_wr_en & coef_wr_ready
                & (int'(coef_wr_addr) < N);
  assign mac_en = (state == ACC);

  // Newest sample sits at wptr; older ones wrap backwards mod N.
  assign idx = (wptr >= k) ? wptr - k
                           : wptr - k + AW'(N);

  // Next state and handshake outputs.
  always_comb begin
    state_nxt     = state;
    x_ready       = 1'b0;
    coef_wr_ready = 1'b0;
    y_valid       = 1'b0;
    unique case (state)
      IDLE: begin
        x_ready       = 1'b1;
        coef_wr_ready = 1'b1;
        if (x_valid)
          state_nxt = ACC;
      end
      ACC: begin
        if (k_last)
          state_nxt = DRAIN;
      end
      DRAIN: state_nxt = OUT;
      OUT: begin
        y_valid = 1'b1;
        if (y_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, tap counter and delay-line write pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
      wptr  <= '0;
    end else begin
      state <= state_nxt;
      k     <= (mac_en && !k_last) ? k + AW'(1) : '0;
      if (state == DRAIN)
        wptr <= (wptr == AW'(N - 1)) ? '0 : wptr + AW'(1);
    end
  end

  // Circular delay line of input samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++)
        dl[i] <= '0;
    end else if (x_hs) begin
      dl[wptr] <= x_data;
    end
  end

  // Coefficient bank, writable only while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++)
        h[i] <= '0;
    end else if (c_hs) begin
      h[coef_wr_addr] <= coef_wr_data;
    end
  end

  fir_mac #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (x_hs),
    .en    (mac_en),
    .a     (h[k]),
    .b     (dl[idx]),
    .acc   (acc)
  );

  // Accumulator is frozen in OUT, so the output stage reads it directly.
  always_comb begin
    acc_x   = {{(SR_W-ACC_W){acc[ACC_W-1]}}, acc};
    sr      = sat_round(acc_x, W, W_FRAC, ROUND != 0);
    y_data  = y_valid ? sr[W-1:0] : '0;
    y_sat   = y_valid & sr[MAX_W];
  end

  assign unused_sr = ^sr;

endmodule

// File: tb/tb_fir_stream_serial.sv
// Self-checking bench for fir_stream_serial (N=4, Q16.16),
// with a ROUND=1 and a ROUND=0 instance on shared stimulus.
module tb_fir_stream_serial;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int LN = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          x_valid;
  logic [W-1:0]  x_data;
  logic          y_ready;
  logic          coef_wr_en;
  logic [1:0]    coef_wr_addr;
  logic [W-1:0]  coef_wr_data;

  logic          x_ready, y_valid, y_sat, coef_wr_ready;
  logic [W-1:0]  y_data;
  logic          x_ready0, y_valid0, y_sat0, coef_wr_ready0;
  logic [W-1:0]  y_data0;

  int checks = 0;
  int errors = 0;

  logic signed [31:0] mh   [N];
  logic signed [31:0] hist [N];

  fir_stream_serial #(.N(N), .W(W), .W_FRAC(16), .ROUND(1)) dut (
    .clk(clk), .reset(reset),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .y_valid(y_valid), .y_ready(y_ready),
    .y_data(y_data), .y_sat(y_sat),
    .coef_wr_en(coef_wr_en), .coef_wr_ready(coef_wr_ready),
    .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data)
  );

  fir_stream_serial #(.N(N), .W(W), .W_FRAC(16), .ROUND(0)) dut0 (
    .clk(clk), .reset(reset),
    .x_valid(x_valid), .x_ready(x_ready0), .x_data(x_data),
    .y_valid(y_valid0), .y_ready(y_ready),
    .y_data(y_data0), .y_sat(y_sat0),
    .coef_wr_en(coef_wr_en), .coef_wr_ready(coef_wr_ready0),
    .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Reference: y[n] = sum h[k]*x[n-k], rounded/floored, clamped.
  function automatic logic [32:0] model_y(input bit rnd);
    logic signed [127:0] s, q, hi, lo;
    s = '0;
    for (int i = 0; i < N; i++)
      s = s + mh[i] * hist[i];
    if (rnd)
      s = s + 128'sd32768;
    q  = s >>> 16;
    hi = 128'sd2147483647;
    lo = -128'sd2147483648;
    if (q > hi) return {1'b1, 32'h7FFFFFFF};
    if (q < lo) return {1'b1, 32'h80000000};
    return {1'b0, q[31:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mh[i]   = '0;
      hist[i] = '0;
    end
  endtask

  task automatic model_push(input logic [31:0] x);
    for (int i = N - 1; i > 0; i--)
      hist[i] = hist[i-1];
    hist[0] = x;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    x_valid      = 1'b0;
    x_data       = '0;
    y_ready      = 1'b0;
    coef_wr_en   = 1'b0;
    coef_wr_addr = '0;
    coef_wr_data = '0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic load_coef(input int a, input logic [31:0] d);
    coef_wr_en   = 1'b1;
    coef_wr_addr = a[1:0];
    coef_wr_data = d;
    tick();
    coef_wr_en = 1'b0;
    mh[a] = d;
  endtask

  function automatic logic [31:0] rnd_small();
    logic [31:0] v;
    v = $urandom_range(0, 32'h000FFFFF) - 32'h00080000;
    return v;
  endfunction

  // Accept one sample, wait for y (latency counted with the
  // accepting edge as edge 1), hold off y_ready, then take y.
  task automatic send(
    input  logic [31:0] x,
    input  int          hold,
    output logic [31:0] y,
    output logic        s,
    output logic [31:0] y0,
    output logic        s0,
    output int          lat
  );
    int w;
    w = 0;
    while (!x_ready && w < 40) begin
      tick();
      w++;
    end
    x_valid = 1'b1;
    x_data  = x;
    tick();
    x_valid = 1'b0;
    model_push(x);
    lat = 1;
    while (!y_valid && lat < 40) begin
      tick();
      lat++;
    end
    y  = y_data;
    s  = y_sat;
    y0 = y_data0;
    s0 = y_sat0;
    repeat (hold) tick();
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (x_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_x_ready got %b want 1", x_ready);
    end
    checks++;
    if (y_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_y_valid got %b want 0", y_valid);
    end
    checks++;
    if (y_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_y_data got %h want 0", y_data);
    end
    checks++;
    if (y_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_y_sat got %b want 0", y_sat);
    end
    checks++;
    if (coef_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_coef_ready got %b want 1", coef_wr_ready);
    end
  endtask

  task automatic test_impulse();
    logic [31:0] exp_y [5];
    logic [31:0] y, y0;
    logic        s, s0;
    int          lat;
    exp_y[0] = 32'h00010000;
    exp_y[1] = 32'h00008000;
    exp_y[2] = 32'h00004000;
    exp_y[3] = 32'h00002000;
    exp_y[4] = 32'h00000000;
    do_reset();
    load_coef(0, 32'h00010000);
    load_coef(1, 32'h00008000);
    load_coef(2, 32'h00004000);
    load_coef(3, 32'h00002000);
    for (int i = 0; i < 5; i++) begin
      send((i == 0) ? 32'h00010000 : 32'h0, 0, y, s, y0, s0, lat);
      checks++;
      if (y !== exp_y[i] || s !== 1'b0) begin
        errors++;
        $display("FAIL impulse_y[%0d] got %h/%b want %h/0",
                 i, y, s, exp_y[i]);
      end
      checks++;
      if (y0 !== exp_y[i]) begin
        errors++;
        $display("FAIL impulse_y0[%0d] got %h want %h",
                 i, y0, exp_y[i]);
      end
      checks++;
      if (lat !== LN) begin
        errors++;
        $display("FAIL impulse_lat[%0d] got %0d want %0d",
                 i, lat, LN);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] e;
    logic [31:0] held;
    int          w, bad, lat;
    do_reset();
    for (int i = 0; i < N; i++)
      load_coef(i, rnd_small());
    x_valid = 1'b1;
    x_data  = rnd_small();
    tick();
    x_valid = 1'b0;
    model_push(x_data);
    e = model_y(1'b1);
    w = 0;
    while (!y_valid && w < 40) begin
      tick();
      w++;
    end
    held    = y_data;
    x_valid = 1'b1;
    x_data  = rnd_small();
    bad     = 0;
    for (int c = 0; c < 10; c++) begin
      if (y_valid !== 1'b1 || y_data !== held ||
          y_data !== e[31:0] || x_ready !== 1'b0 ||
          coef_wr_ready !== 1'b0)
        bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold bad_cycles %0d want 0 (y %h want %h)",
               bad, y_data, e[31:0]);
    end
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    checks++;
    if (x_ready !== 1'b1 || y_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release x_ready %b y_valid %b want 1/0",
               x_ready, y_valid);
    end
    tick();
    x_valid = 1'b0;
    model_push(x_data);
    e   = model_y(1'b1);
    lat = 1;
    while (!y_valid && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (y_data !== e[31:0] || lat !== LN) begin
      errors++;
      $display("FAIL bp_next got %h lat %0d want %h lat %0d",
               y_data, lat, e[31:0], LN);
    end
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
  endtask

  task automatic test_saturation();
    logic [31:0] y, y0;
    logic        s, s0;
    logic [32:0] e;
    int          lat;
    do_reset();
    for (int i = 0; i < N; i++)
      load_coef(i, 32'h7FFF0000);
    for (int i = 0; i < 8; i++) begin
      send((i < 4) ? 32'h7FFFFFFF : 32'h80000000,
           0, y, s, y0, s0, lat);
      e = model_y(1'b1);
      checks++;
      if ({s, y} !== e) begin
        errors++;
        $display("FAIL sat_model[%0d] got %b/%h want %b/%h",
                 i, s, y, e[32], e[31:0]);
      end
      if (i == 3) begin
        checks++;
        if (y !== 32'h7FFFFFFF || s !== 1'b1) begin
          errors++;
          $display("FAIL sat_pos got %h/%b want 7fffffff/1", y, s);
        end
      end
      if (i == 7) begin
        checks++;
        if (y !== 32'h80000000 || s !== 1'b1 ||
            y0 !== 32'h80000000 || s0 !== 1'b1) begin
          errors++;
          $display("FAIL sat_neg got %h/%b want 80000000/1", y, s);
        end
      end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] y, y0;
    logic        s, s0;
    int          lat;
    do_reset();
    load_coef(0, 32'h00008000);
    send(32'h00000001, 0, y, s, y0, s0, lat);
    checks++;
    if (y !== 32'h1 || y0 !== 32'h0) begin
      errors++;
      $display("FAIL round_half got r1 %h r0 %h want 1/0", y, y0);
    end
    send(32'hFFFFFFFF, 0, y, s, y0, s0, lat);
    checks++;
    if (y !== 32'h0 || y0 !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL round_neg got r1 %h r0 %h want 0/ffffffff",
               y, y0);
    end
  endtask

  task automatic test_coef_busy();
    logic [31:0] y, y0, d0, d1;
    logic        s, s0;
    logic [32:0] e;
    int          w, lat;
    do_reset();
    for (int i = 0; i < N; i++)
      load_coef(i, rnd_small() | 32'h1);
    for (int i = 0; i < 3; i++)
      send(rnd_small() | 32'h100, 0, y, s, y0, s0, lat);
    d0 = rnd_small() | 32'h10000;
    d1 = rnd_small() | 32'h10000;
    x_valid = 1'b1;
    x_data  = rnd_small() | 32'h100;
    tick();
    x_valid = 1'b0;
    model_push(x_data);
    e = model_y(1'b1);
    coef_wr_en   = 1'b1;
    coef_wr_addr = 2'd1;
    coef_wr_data = d1;
    checks++;
    if (coef_wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_coef_ready got %b want 0", coef_wr_ready);
    end
    tick();
    tick();
    coef_wr_addr = 2'd0;
    coef_wr_data = d0;
    w = 0;
    while (!y_valid && w < 40) begin
      tick();
      w++;
    end
    checks++;
    if (y_data !== e[31:0] || coef_wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_old_coefs got %h want %h", y_data, e[31:0]);
    end
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    tick();
    coef_wr_en = 1'b0;
    mh[0] = d0;
    send(rnd_small() | 32'h100, 0, y, s, y0, s0, lat);
    e = model_y(1'b1);
    checks++;
    if (y !== e[31:0]) begin
      errors++;
      $display("FAIL busy_new_coefs got %h want %h", y, e[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] y, y0;
    logic        s, s0;
    int          lat, seen;
    do_reset();
    for (int i = 0; i < N; i++)
      load_coef(i, rnd_small() | 32'h10000);
    x_valid = 1'b1;
    x_data  = 32'h00010000;
    tick();
    x_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    checks++;
    if (x_ready !== 1'b1 || y_valid !== 1'b0 ||
        coef_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_state x_ready %b y_valid %b want 1/0",
               x_ready, y_valid);
    end
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (y_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_no_y got %0d valid cycles want 0", seen);
    end
    for (int i = 0; i < 5; i++) begin
      send((i == 0) ? 32'h00010000 : 32'h0, 0, y, s, y0, s0, lat);
      checks++;
      if (y !== 32'h0 || s !== 1'b0 || lat !== LN) begin
        errors++;
        $display("FAIL midrst_impulse[%0d] got %h lat %0d want 0 lat %0d",
                 i, y, lat, LN);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] y, y0, xv;
    logic        s, s0;
    logic [32:0] e1, e0;
    int          lat;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++)
        load_coef(i, (r == 2) ? $urandom : rnd_small());
      for (int i = 0; i < 8; i++) begin
        xv = (r == 0) ? rnd_small() : $urandom;
        send(xv, $urandom_range(0, 3), y, s, y0, s0, lat);
        e1 = model_y(1'b1);
        e0 = model_y(1'b0);
        checks++;
        if ({s, y} !== e1 || {s0, y0} !== e0 || lat !== LN) begin
          errors++;
          $display("FAIL rand[%0d.%0d] got %b/%h %b/%h lat %0d want %b/%h %b/%h",
                   r, i, s, y, s0, y0, lat, e1[32], e1[31:0],
                   e0[32], e0[31:0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] q [$];
    logic [32:0] e;
    int          acc_cyc [$];
    int          missing, prev;
    do_reset();
    for (int i = 0; i < N; i++)
      load_coef(i, rnd_small());
    y_ready = 1'b1;
    x_valid = 1'b1;
    x_data  = rnd_small();
    prev    = 0;
    for (int c = 0; c < 60; c++) begin
      if (prev) x_data = rnd_small();
      if (y_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_y got %h want none", y_data);
        end else begin
          e = q.pop_front();
          if ({y_sat, y_data} !== e) begin
            errors++;
            $display("FAIL b2b_y got %h want %h", y_data, e[31:0]);
          end
        end
      end
      prev = x_ready;
      if (x_ready) begin
        model_push(x_data);
        q.push_back(model_y(1'b1));
        acc_cyc.push_back(c);
      end
      tick();
    end
    x_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (y_valid && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({y_sat, y_data} !== e) begin
          errors++;
          $display("FAIL b2b_tail got %h want %h", y_data, e[31:0]);
        end
      end
      tick();
    end
    y_ready = 1'b0;
    missing = q.size();
    checks++;
    if (missing != 0 || acc_cyc.size() < 5) begin
      errors++;
      $display("FAIL b2b_count missing %0d accepts %0d want 0/>=5",
               missing, acc_cyc.size());
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != N + 3) begin
        errors++;
        $display("FAIL b2b_spacing got %0d want %0d",
                 acc_cyc[i] - acc_cyc[i-1], N + 3);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    x_valid      = 1'b0;
    x_data       = '0;
    y_ready      = 1'b0;
    coef_wr_en   = 1'b0;
    coef_wr_addr = '0;
    coef_wr_data = '0;
    test_reset();
    test_impulse();
    test_backpressure();
    test_saturation();
    test_rounding();
    test_coef_busy();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
